// File: rtl/abr_masked_pkg.sv
// Shared types and constants for the masked AND/OR datapath blocks.
package abr_masked_pkg;

   localparam int ABR_MASKED_SHARES = 2;

   typedef enum logic {
      ABR_MASKED_AND = 1'b0,
      ABR_MASKED_OR  = 1'b1
   } abr_masked_op_e;

endpackage

// File: rtl/abr_masked_and_core.sv
// WIDTH-lane domain-oriented masked AND, 2 shares.
// Cross-domain products are refreshed with rnd and registered before any
// recombination; s0/s1 are only formed from the registered terms, so no
// combinational path ever mixes the two share domains ahead of the register.
module abr_masked_and_core
   import abr_masked_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             zeroize,
   input  logic             en,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] b1,
   input  logic [WIDTH-1:0] rnd,
   output logic [WIDTH-1:0] s0,
   output logic [WIDTH-1:0] s1
);

   logic [WIDTH-1:0] r00;
   logic [WIDTH-1:0] r01;
   logic [WIDTH-1:0] r10;
   logic [WIDTH-1:0] r11;

   // Reshare registers: load only with a valid operation so idle cycles do
   // not toggle share state; zeroize wins over a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r00 <= '0;
         r01 <= '0;
         r10 <= '0;
         r11 <= '0;
      end else if (zeroize) begin
         r00 <= '0;
         r01 <= '0;
         r10 <= '0;
         r11 <= '0;
      end else if (en) begin
         r00 <= a0 & b0;
         r01 <= (a0 & b1) ^ rnd;
         r10 <= (a1 & b0) ^ rnd;
         r11 <= a1 & b1;
      end
   end

   assign s0 = r00 ^ r01;
   assign s1 = r10 ^ r11;

endmodule

// File: rtl/abr_masked_and_pipe.sv
// Masked AND/OR unit: operand pre-transform for OR (De Morgan on share 0),
// masked AND core, mode/valid pipe and optional output register stage.
// Latency is 1+OUT_REG cycles, one operation accepted per cycle.
module abr_masked_and_pipe
   import abr_masked_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int OUT_REG = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             zeroize,
   input  logic             valid_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] x0_i,
   input  logic [WIDTH-1:0] x1_i,
   input  logic [WIDTH-1:0] y0_i,
   input  logic [WIDTH-1:0] y1_i,
   input  logic [WIDTH-1:0] rnd_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] c0_o,
   output logic [WIDTH-1:0] c1_o
);

   abr_masked_op_e   op_in;
   abr_masked_op_e   m1;
   logic             v1;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] s0_raw;
   logic [WIDTH-1:0] s0;
   logic [WIDTH-1:0] s1;

   assign op_in = abr_masked_op_e'(mode_i);

   // OR is computed as ~(~x & ~y): inverting share 0 inverts the unmasked value.
   assign a0 = (op_in == ABR_MASKED_OR) ? ~x0_i : x0_i;
   assign b0 = (op_in == ABR_MASKED_OR) ? ~y0_i : y0_i;

   abr_masked_and_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .zeroize (zeroize),
      .en      (valid_i),
      .a0      (a0),
      .a1      (x1_i),
      .b0      (b0),
      .b1      (y1_i),
      .rnd     (rnd_i),
      .s0      (s0_raw),
      .s1      (s1)
   );

   // Mode travels with its data (loaded only on valid); valid bit follows valid_i.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 <= ABR_MASKED_AND;
         v1 <= 1'b0;
      end else if (zeroize) begin
         m1 <= ABR_MASKED_AND;
         v1 <= 1'b0;
      end else begin
         v1 <= valid_i;
         if (valid_i) begin
            m1 <= op_in;
         end
      end
   end

   // Output inversion completing De Morgan, applied to share 0 only.
   assign s0 = s0_raw ^ {WIDTH{m1 == ABR_MASKED_OR}};

   if (OUT_REG != 0) begin : g_out_reg
      logic             v2;
      logic [WIDTH-1:0] c0_q;
      logic [WIDTH-1:0] c1_q;

      // Output stage: captures a result only when stage 1 holds a new one.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v2   <= 1'b0;
            c0_q <= '0;
            c1_q <= '0;
         end else if (zeroize) begin
            v2   <= 1'b0;
            c0_q <= '0;
            c1_q <= '0;
         end else begin
            v2 <= v1;
            if (v1) begin
               c0_q <= s0;
               c1_q <= s1;
            end
         end
      end

      assign valid_o = v2;
      assign c0_o    = c0_q;
      assign c1_o    = c1_q;
   end else begin : g_no_out_reg
      assign valid_o = v1;
      assign c0_o    = s0;
      assign c1_o    = s1;
   end

endmodule

// File: tb/tb_abr_masked_and_pipe.sv
// Bench for abr_masked_and_pipe: one instance per output-stage option, a
// share-level algebraic model with a pending-result queue, and directed
// literal checks of the expected shares and unmasked results.
module tb_abr_masked_and_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         zeroize = 1'b0;
   logic         valid_i = 1'b0;
   logic         mode_i = 1'b0;
   logic [W-1:0] x0_i = '0;
   logic [W-1:0] x1_i = '0;
   logic [W-1:0] y0_i = '0;
   logic [W-1:0] y1_i = '0;
   logic [W-1:0] rnd_i = '0;

   logic         valid0, valid1;
   logic [W-1:0] c0_0, c1_0, c0_1, c1_1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   abr_masked_and_pipe #(.WIDTH(W), .OUT_REG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .zeroize(zeroize), .valid_i(valid_i), .mode_i(mode_i),
      .x0_i(x0_i), .x1_i(x1_i), .y0_i(y0_i), .y1_i(y1_i), .rnd_i(rnd_i),
      .valid_o(valid0), .c0_o(c0_0), .c1_o(c1_0));

   abr_masked_and_pipe #(.WIDTH(W), .OUT_REG(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .zeroize(zeroize), .valid_i(valid_i), .mode_i(mode_i),
      .x0_i(x0_i), .x1_i(x1_i), .y0_i(y0_i), .y1_i(y1_i), .rnd_i(rnd_i),
      .valid_o(valid1), .c0_o(c0_1), .c1_o(c1_1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct {
      int           due;
      logic [W-1:0] c0;
      logic [W-1:0] c1;
   } pend_t;

   pend_t        pq0[$];
   pend_t        pq1[$];
   int           cyc = 0;
   logic         ev0 = 1'b0, ev1 = 1'b0;
   logic [W-1:0] ec0_0 = '0, ec1_0 = '0, ec0_1 = '0, ec1_1 = '0;

   // Shares by algebra: c0 = a0&(b0^b1)^rnd (^1 for OR), c1 = a1&(b0^b1)^rnd.
   function automatic void model_shares(input logic m, input logic [W-1:0] x0, x1, y0, y1, r,
                                        output logic [W-1:0] c0, output logic [W-1:0] c1);
      logic [W-1:0] y;
      y = y0 ^ y1;
      if (!m) begin
         c0 = (x0 & y) ^ r;
         c1 = (x1 & y) ^ r;
      end else begin
         c0 = ~((~x0 & ~y) ^ r);
         c1 = (x1 & ~y) ^ r;
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pq0.delete(); pq1.delete();
         ev0 = 0; ev1 = 0;
         ec0_0 = 0; ec1_0 = 0; ec0_1 = 0; ec1_1 = 0;
      end else begin
         cyc++;
         if (zeroize) begin
            pq0.delete(); pq1.delete();
            ev0 = 0; ev1 = 0;
            ec0_0 = 0; ec1_0 = 0; ec0_1 = 0; ec1_1 = 0;
         end else begin
            ev0 = 0; ev1 = 0;
            if (valid_i) begin
               pend_t p;
               model_shares(mode_i, x0_i, x1_i, y0_i, y1_i, rnd_i, p.c0, p.c1);
               p.due = cyc;     pq0.push_back(p);
               p.due = cyc + 1; pq1.push_back(p);
            end
            if (pq0.size() > 0 && pq0[0].due == cyc) begin
               ev0 = 1; ec0_0 = pq0[0].c0; ec1_0 = pq0[0].c1; void'(pq0.pop_front());
            end
            if (pq1.size() > 0 && pq1[0].due == cyc) begin
               ev1 = 1; ec0_1 = pq1[0].c0; ec1_1 = pq1[0].c1; void'(pq1.pop_front());
            end
         end
      end
   end

   // Every cycle: outputs either carry a new result or hold the previous one.
   always @(negedge clk) begin
      chk("cmp_valid_lat1", {31'd0, valid0}, {31'd0, ev0});
      chk("cmp_c0_lat1", {24'd0, c0_0}, {24'd0, ec0_0});
      chk("cmp_c1_lat1", {24'd0, c1_0}, {24'd0, ec1_0});
      chk("cmp_valid_lat2", {31'd0, valid1}, {31'd0, ev1});
      chk("cmp_c0_lat2", {24'd0, c0_1}, {24'd0, ec0_1});
      chk("cmp_c1_lat2", {24'd0, c1_1}, {24'd0, ec1_1});
   end

   // ---------------- stimulus ----------------
   task automatic op(input logic m, input logic [W-1:0] x0, x1, y0, y1, r, input logic z);
      valid_i = 1'b1; mode_i = m; zeroize = z;
      x0_i = x0; x1_i = x1; y0_i = y0; y1_i = y1; rnd_i = r;
   endtask

   task automatic idle();
      valid_i = 1'b0; zeroize = 1'b0; mode_i = 1'b0;
      x0_i = '0; x1_i = '0; y0_i = '0; y1_i = '0; rnd_i = '0;
   endtask

   logic [W-1:0] c0_r00;
   logic [W-1:0] c0_rff;

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_valid0", {31'd0, valid0}, 0);
      chk("reset_valid1", {31'd0, valid1}, 0);
      chk("reset_c", {16'd0, c0_0, c1_0}, 0);
      rst_n = 1'b1;

      // AND, rnd 5A
      @(negedge clk); op(0, 8'h3C, 8'h99, 8'hF0, 8'hFF, 8'h5A, 0);
      @(negedge clk); idle();
      chk("and_valid", {31'd0, valid0}, 1);
      chk("and_c0", {24'd0, c0_0}, 32'h56);
      chk("and_c1", {24'd0, c1_0}, 32'h53);
      chk("and_unmasked", {24'd0, c0_0 ^ c1_0}, 32'h05);
      chk("and_lat2_not_yet", {31'd0, valid1}, 0);
      @(negedge clk);
      chk("and_lat2_valid", {31'd0, valid1}, 1);
      chk("and_lat2_unmasked", {24'd0, c0_1 ^ c1_1}, 32'h05);

      // OR, rnd 5A
      @(negedge clk); op(1, 8'h3C, 8'h99, 8'hF0, 8'hFF, 8'h5A, 0);
      @(negedge clk); idle();
      chk("or_valid", {31'd0, valid0}, 1);
      chk("or_c0", {24'd0, c0_0}, 32'h65);
      chk("or_c1", {24'd0, c1_0}, 32'hCA);
      chk("or_unmasked", {24'd0, c0_0 ^ c1_0}, 32'hAF);
      @(negedge clk);
      chk("or_hold_valid", {31'd0, valid0}, 0);
      chk("or_hold_c0", {24'd0, c0_0}, 32'h65);

      // rnd independence
      @(negedge clk); op(0, 8'h3C, 8'h99, 8'hF0, 8'hFF, 8'h00, 0);
      @(negedge clk); idle();
      c0_r00 = c0_0;
      chk("rnd00_c0", {24'd0, c0_0}, 32'h0C);
      chk("rnd00_unmasked", {24'd0, c0_0 ^ c1_0}, 32'h05);
      @(negedge clk); op(0, 8'h3C, 8'h99, 8'hF0, 8'hFF, 8'hFF, 0);
      @(negedge clk); idle();
      c0_rff = c0_0;
      chk("rndff_c0", {24'd0, c0_0}, 32'hF3);
      chk("rndff_unmasked", {24'd0, c0_0 ^ c1_0}, 32'h05);
      chk("rnd_c0_differs", {31'd0, c0_r00 != c0_rff}, 1);
      @(negedge clk);

      // back-to-back, alternating mode, latency 2
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i < 4) op(i[0], 8'h3C, 8'h99, 8'hF0, 8'hFF, W'($urandom), 0);
         else idle();
         if (i >= 2 && i < 6) begin
            chk("b2b_valid", {31'd0, valid1}, 1);
            chk("b2b_unmasked", {24'd0, c0_1 ^ c1_1}, ((i - 2) % 2 == 0) ? 32'h05 : 32'hAF);
         end else if (i >= 6) begin
            chk("b2b_valid_end", {31'd0, valid1}, 0);
         end
      end

      // zeroize with a result in flight and a valid in the same cycle
      @(negedge clk); op(0, 8'h3C, 8'h99, 8'hF0, 8'hFF, 8'h33, 0);
      @(negedge clk); op(1, 8'h3C, 8'h99, 8'hF0, 8'hFF, 8'h44, 1);
      @(negedge clk); idle();
      chk("zero_valid0", {31'd0, valid0}, 0);
      chk("zero_valid1", {31'd0, valid1}, 0);
      chk("zero_c_lat1", {16'd0, c0_0, c1_0}, 0);
      chk("zero_c_lat2", {16'd0, c0_1, c1_1}, 0);
      repeat (2) begin
         @(negedge clk);
         chk("zero_no_late_valid", {30'd0, valid0, valid1}, 0);
      end

      // async reset while a latency-2 result is on the output
      @(negedge clk); op(0, 8'h3C, 8'h99, 8'hF0, 8'hFF, 8'hC3, 0);
      @(negedge clk); idle();
      @(posedge clk); #2;
      chk("prerst_valid1", {31'd0, valid1}, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_valid1", {31'd0, valid1}, 0);
      chk("rst_c_lat2", {16'd0, c0_1, c1_1}, 0);
      chk("rst_valid0", {31'd0, valid0}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); op(1, 8'h3C, 8'h99, 8'hF0, 8'hFF, 8'h77, 0);
      @(negedge clk); idle();
      chk("postrst_not_yet", {31'd0, valid1}, 0);
      @(negedge clk);
      chk("postrst_valid", {31'd0, valid1}, 1);
      chk("postrst_c0", {24'd0, c0_1}, 32'h48);
      chk("postrst_unmasked", {24'd0, c0_1 ^ c1_1}, 32'hAF);

      // random traffic, checked by the model
      repeat (80) begin
         @(negedge clk);
         valid_i = $urandom_range(0, 1) == 1;
         mode_i  = $urandom_range(0, 1) == 1;
         zeroize = $urandom_range(0, 15) == 0;
         x0_i = W'($urandom); x1_i = W'($urandom);
         y0_i = W'($urandom); y1_i = W'($urandom);
         rnd_i = W'($urandom);
      end
      @(negedge clk); idle();
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
